// File: rtl/spi_frame_master.sv
// Mode-0 SPI master: shifts a fixed NUM_BYTES frame full-duplex under a start/busy/done handshake.
// cs_n, sck and the shift timing all come from clk50M. MOSI is taken straight from the MSB of the transmit shift register.
module spi_frame_master #(
  parameter int CLK_DIV   = 25,
  parameter int NUM_BYTES = 5,
  parameter int CS_SETUP  = 15,
  parameter int BYTE_GAP  = 10
) (
  input  logic                   clk50M,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [8*NUM_BYTES-1:0] tx_data,
  output logic                   busy,
  output logic                   done,
  output logic [8*NUM_BYTES-1:0] rx_data,
  output logic                   cs_n,
  output logic                   sck,
  output logic                   mosi,
  input  logic                   miso
);

  localparam int FW    = 8 * NUM_BYTES;
  localparam int MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAXV  = (MAX_A > BYTE_GAP) ? MAX_A : BYTE_GAP;
  localparam int CW    = $clog2(MAXV + 1);
  localparam int BW    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'((BYTE_GAP > 0) ? BYTE_GAP - 1 : 0);
  localparam logic [BW-1:0] BYTE_LAST  = BW'(NUM_BYTES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, HOLD} state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [2:0]      bit_reg;
  logic [BW-1:0]   byte_reg;
  logic [FW-1:0]   tx_sr_reg;
  logic [FW-1:0]   rx_sr_reg;

  // Zeros shift in behind the frame, so mosi is already 0 when the frame ends.
  assign mosi = tx_sr_reg[FW-1];

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      byte_reg  <= '0;
      tx_sr_reg <= '0;
      rx_sr_reg <= '0;
      rx_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cs_n      <= 1'b1;
      sck       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            tx_sr_reg <= tx_data;
            cs_n      <= 1'b0;
            busy      <= 1'b1;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            byte_reg  <= '0;
            state_reg <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_reg == SETUP_LAST) begin
            cnt_reg   <= '0;
            state_reg <= SHIFT;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        SHIFT: begin
          if (cnt_reg != DIV_LAST) begin
            cnt_reg <= cnt_reg + 1'b1;
          end else begin
            cnt_reg <= '0;
            if (!sck) begin
              sck       <= 1'b1;
              rx_sr_reg <= {rx_sr_reg[FW-2:0], miso};
            end else begin
              // Falling edge: advance MOSI and decide where the frame goes next.
              sck       <= 1'b0;
              tx_sr_reg <= {tx_sr_reg[FW-2:0], 1'b0};
              bit_reg   <= bit_reg + 1'b1;
              if (bit_reg == 3'd7) begin
                if (byte_reg == BYTE_LAST) begin
                  state_reg <= HOLD;
                end else begin
                  byte_reg <= byte_reg + 1'b1;
                  if (BYTE_GAP > 0)
                    state_reg <= GAP;
                end
              end
            end
          end
        end
        GAP: begin
          if (cnt_reg == GAP_LAST) begin
            cnt_reg   <= '0;
            state_reg <= SHIFT;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        HOLD: begin
          if (cnt_reg == SETUP_LAST) begin
            cnt_reg   <= '0;
            state_reg <= IDLE;
            cs_n      <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            rx_data   <= rx_sr_reg;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_master.sv
// Scoreboard bench for spi_frame_master: stimulus queues expected frames, a negedge monitor checks them.
// A behavioural mode-0 slave (or a mosi->miso loopback) supplies miso; a second instance uses default parameters.
module tb_spi_frame_master;

  localparam int CD  = 2;
  localparam int NB  = 2;
  localparam int CSU = 3;
  localparam int GP  = 4;
  localparam int FW  = 8 * NB;
  localparam int EXP_BUSY = CSU + NB * 16 * CD + (NB - 1) * GP + CSU;

  logic          clk50M = 1'b0;
  logic          rst_n  = 1'b0;
  logic          start  = 1'b0;
  logic [FW-1:0] tx_data = '0;
  logic [FW-1:0] rx_data;
  logic          busy, done, cs_n, sck, mosi, miso;

  logic          loop_en = 1'b1;
  logic [FW-1:0] slave_frame = '0;
  int            slave_idx = 0;

  logic          start_d = 1'b0;
  logic [39:0]   tx_d = '0;
  logic [39:0]   rx_d;
  logic          busy_d, done_d, cs_n_d, sck_d, mosi_d;

  int checks = 0;
  int errors = 0;

  logic [FW-1:0] exp_rx_q[$];
  logic [FW-1:0] exp_tx_q[$];

  always #5 clk50M = ~clk50M;

  spi_frame_master #(.CLK_DIV(CD), .NUM_BYTES(NB), .CS_SETUP(CSU), .BYTE_GAP(GP)) dut (
    .clk50M(clk50M), .rst_n(rst_n), .start(start), .tx_data(tx_data),
    .busy(busy), .done(done), .rx_data(rx_data),
    .cs_n(cs_n), .sck(sck), .mosi(mosi), .miso(miso)
  );

  spi_frame_master dut_d (
    .clk50M(clk50M), .rst_n(rst_n), .start(start_d), .tx_data(tx_d),
    .busy(busy_d), .done(done_d), .rx_data(rx_d),
    .cs_n(cs_n_d), .sck(sck_d), .mosi(mosi_d), .miso(mosi_d)
  );

  // Mode-0 slave: presents its next bit after every sck fall, MSB first.
  assign miso = loop_en ? mosi : ((slave_idx < FW) ? slave_frame[FW-1-slave_idx] : 1'b0);

  always @(negedge sck or posedge cs_n) begin
    if (cs_n) slave_idx <= 0;
    else      slave_idx <= slave_idx + 1;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic          p_sck, p_cs_n, p_busy, p_done, p_mosi, mosi_high;
  int            busy_len, rise_cnt, since_cs, since_rise, since_fall;
  logic [FW-1:0] mosi_cap;

  always @(negedge clk50M) begin
    if (!rst_n) begin
      p_sck = 0; p_cs_n = 1; p_busy = 0; p_done = 0; p_mosi = 0; mosi_high = 0;
      busy_len = 0; rise_cnt = 0; since_cs = 0; since_rise = 0; since_fall = 0;
      mosi_cap = '0;
    end else begin
      since_cs++; since_rise++; since_fall++;
      if (busy) busy_len++;
      if (p_busy && !busy) begin
        chk("busy_len", busy_len, EXP_BUSY);
        busy_len = 0;
      end
      if (cs_n && sck) chk("sck_while_cs_high", sck, 0);
      if (p_cs_n && !cs_n) begin
        since_cs = 0; rise_cnt = 0; mosi_high = 0; mosi_cap = '0;
      end
      if (!cs_n && mosi) mosi_high = 1;
      if (!p_sck && sck) begin
        rise_cnt++;
        if (rise_cnt == 1) chk("cs_to_first_rise", since_cs, CSU + CD);
        else chk("rise_interval", since_rise, (rise_cnt == 9) ? (2 * CD + GP) : 2 * CD);
        chk("mosi_stable_at_rise", mosi, p_mosi);
        mosi_cap = {mosi_cap[FW-2:0], mosi};
        since_rise = 0;
      end
      if (p_sck && !sck) since_fall = 0;
      if (!p_cs_n && cs_n) begin
        chk("last_fall_to_cs_rise", since_fall, CSU);
        chk("sck_rises_in_frame", rise_cnt, FW);
      end
      if (done) begin
        chk("done_one_cycle", p_done, 0);
        chk("mosi_zero_after_frame", mosi, 0);
        if (exp_rx_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          logic [FW-1:0] erx, etx;
          erx = exp_rx_q.pop_front();
          etx = exp_tx_q.pop_front();
          $display("frame: rx=%h exp_rx=%h mosi=%h exp_tx=%h", rx_data, erx, mosi_cap, etx);
          chk("rx_data", rx_data, erx);
          chk("mosi_stream", mosi_cap, etx);
          if (etx == '0) chk("mosi_stayed_low", mosi_high, 0);
        end
      end
      p_sck = sck; p_cs_n = cs_n; p_busy = busy; p_done = done; p_mosi = mosi;
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_frame(input logic [FW-1:0] tx, input bit lp, input logic [FW-1:0] sf,
                             input bit now);
    if (!now) begin
      @(posedge clk50M); #1;
    end
    loop_en = lp;
    slave_frame = sf;
    tx_data = tx;
    exp_rx_q.push_back(lp ? tx : sf);
    exp_tx_q.push_back(tx);
    start = 1'b1;
    @(posedge clk50M); #1;
    start = 1'b0;
    tx_data = FW'($urandom);
    chk("accept_cs_n", cs_n, 0);
    chk("accept_busy", busy, 1);
    chk("accept_mosi_msb", mosi, tx[FW-1]);
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk50M); #1;
      if (done) begin
        seen = 1;
        break;
      end
    end
    chk("done_timeout", seen, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk50M);
    #1;
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sck", sck, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rx", rx_data, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk50M);

    // Loopback and slave-driven frames
    start_frame(16'hA55A, 1, 16'h0000, 0);
    wait_done();
    start_frame(16'h0000, 0, 16'h3CC3, 0);
    wait_done();

    // Mid-frame start pulses are ignored; a done-cycle start chains a new frame
    start_frame(16'h1234, 1, 16'h0000, 0);
    repeat (9) @(posedge clk50M);
    #1 start = 1'b1;
    @(posedge clk50M); #1 start = 1'b0;
    repeat (29) @(posedge clk50M);
    #1 start = 1'b1;
    @(posedge clk50M); #1 start = 1'b0;
    wait_done();
    start_frame(16'h5AA5, 0, 16'h0F0F, 1);
    wait_done();

    // Asynchronous reset mid-frame
    start_frame(16'hC0DE, 1, 16'h0000, 0);
    repeat (29) @(posedge clk50M);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_cs_n", cs_n, 1);
    chk("abort_sck", sck, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rx", rx_data, 0);
    chk("abort_done", done, 0);
    void'(exp_rx_q.pop_back());
    void'(exp_tx_q.pop_back());
    @(posedge clk50M);
    @(negedge clk50M);
    @(posedge clk50M); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk50M);
    start_frame(16'hBEEF, 1, 16'h0000, 0);
    wait_done();

    // Randomised frames, some chained from the done cycle
    for (int n = 0; n < 10; n++) begin
      start_frame(FW'($urandom), 1'($urandom_range(0, 1)), FW'($urandom),
                  1'($urandom_range(0, 1)));
      wait_done();
    end
    repeat (3) @(posedge clk50M);

    // Default-parameter instance: 5-byte loopback
    begin
      int blen = 0, r1 = -1, r2 = -1, cyc = 0;
      bit psck = 0, seen = 0;
      tx_d = 40'h0123456789;
      @(posedge clk50M); #1 start_d = 1'b1;
      @(posedge clk50M); #1 start_d = 1'b0;
      tx_d = '0;
      for (int i = 0; i < 3000; i++) begin
        @(negedge clk50M);
        cyc++;
        if (busy_d) blen++;
        if (sck_d && !psck) begin
          if (r1 < 0) r1 = cyc;
          else if (r2 < 0) r2 = cyc;
        end
        psck = sck_d;
        if (done_d) begin
          seen = 1;
          break;
        end
      end
      $display("default frame: rx=%h busy=%0d sck_period=%0d", rx_d, blen, r2 - r1);
      chk("def_done_seen", seen, 1);
      chk("def_busy_len", blen, 2070);
      chk("def_sck_period", r2 - r1, 50);
      chk("def_rx", rx_d, 40'h0123456789);
    end

    chk("scoreboard_empty", exp_rx_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
